// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : Load-use / multi-cycle stall and branch flush control for the
//            in-order pipeline, with a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_ctrl #(
    parameter int LOAD_LAT   = 2,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_if_id_Rs1,
    input  logic [4:0]       i_if_id_Rs2,
    input  logic             i_if_id_use_rs1,
    input  logic             i_if_id_use_rs2,
    input  logic [4:0]       i_id_ex_Rd,
    input  logic             i_id_ex_MemRead,
    input  logic             i_branch_taken,
    input  logic             i_mc_start,
    input  logic             i_mc_done,
    output logic             o_pc_write,
    output logic             o_if_id_write,
    output logic             o_id_ex_bubble,
    output logic             o_if_id_flush,
    output logic             o_ex_hold,
    output logic             o_mc_timeout,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam logic [1:0] c_st_run      = 2'd0;
    localparam logic [1:0] c_st_ld_stall = 2'd1;
    localparam logic [1:0] c_st_mc_busy  = 2'd2;

    localparam int                 c_tmo_w    = $clog2(MC_TIMEOUT + 1);
    localparam logic [3:0]         c_lat_last = 4'(LOAD_LAT - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(MC_TIMEOUT - 1);

    logic [1:0]         r_state;
    logic [3:0]         r_lat_cnt;
    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic               r_mc_timeout;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic [1:0]         w_next_state;
    logic [3:0]         w_lat_next;
    logic [c_tmo_w-1:0] w_tmo_next;
    logic               w_set_timeout;
    logic               w_load_use;
    logic               w_pc_write;
    logic               w_if_id_write;
    logic               w_bubble;
    logic               w_flush;
    logic               w_hold;

    assign w_load_use = i_id_ex_MemRead && (i_id_ex_Rd != 5'd0) &&
                        ((i_if_id_use_rs1 && (i_id_ex_Rd == i_if_id_Rs1)) ||
                         (i_if_id_use_rs2 && (i_id_ex_Rd == i_if_id_Rs2)));

    always_comb begin
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_bubble      = 1'b0;
        w_flush       = 1'b0;
        w_hold        = 1'b0;
        w_next_state  = r_state;
        w_lat_next    = r_lat_cnt;
        w_tmo_next    = r_tmo_cnt;
        w_set_timeout = 1'b0;
        case (r_state)
            c_st_run: begin
                if (i_branch_taken) begin
                    w_flush  = 1'b1;
                    w_bubble = 1'b1;
                end else if (i_mc_start) begin
                    if (!i_mc_done) begin
                        w_pc_write    = 1'b0;
                        w_if_id_write = 1'b0;
                        w_hold        = 1'b1;
                        w_next_state  = c_st_mc_busy;
                        w_tmo_next    = c_tmo_w'(1);
                    end
                end else if (w_load_use) begin
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                    w_bubble      = 1'b1;
                    // A single-cycle load latency is fully covered by this bubble
                    if (LOAD_LAT > 1) begin
                        w_next_state = c_st_ld_stall;
                        w_lat_next   = 4'd1;
                    end
                end
            end
            c_st_ld_stall: begin
                if (i_branch_taken) begin
                    w_flush      = 1'b1;
                    w_bubble     = 1'b1;
                    w_next_state = c_st_run;
                end else begin
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                    w_bubble      = 1'b1;
                    if (r_lat_cnt == c_lat_last) begin
                        w_next_state = c_st_run;
                    end else begin
                        w_lat_next = r_lat_cnt + 4'd1;
                    end
                end
            end
            c_st_mc_busy: begin
                // EX is frozen here, so a branch indication cannot be trusted
                if (i_mc_done) begin
                    w_next_state = c_st_run;
                end else begin
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                    w_hold        = 1'b1;
                    if (r_tmo_cnt == c_tmo_last) begin
                        w_set_timeout = 1'b1;
                        w_next_state  = c_st_run;
                    end else begin
                        w_tmo_next = r_tmo_cnt + c_tmo_w'(1);
                    end
                end
            end
            default: w_next_state = c_st_run;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= c_st_run;
            r_lat_cnt    <= 4'd0;
            r_tmo_cnt    <= '0;
            r_mc_timeout <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            r_state   <= w_next_state;
            r_lat_cnt <= w_lat_next;
            r_tmo_cnt <= w_tmo_next;
            if (w_set_timeout) begin
                r_mc_timeout <= 1'b1;
            end
            if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign o_pc_write     = w_pc_write;
    assign o_if_id_write  = w_if_id_write;
    assign o_id_ex_bubble = w_bubble;
    assign o_if_id_flush  = w_flush;
    assign o_ex_hold      = w_hold;
    assign o_mc_timeout   = r_mc_timeout;
    assign o_stall_cnt    = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Purpose  : Directed plus randomized checking of hazard_stall_ctrl against a
//            cycle-level behavioural model of the stall/flush rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

    localparam int LOAD_LAT   = 2;
    localparam int MC_TIMEOUT = 64;
    localparam int CNT_W      = 8;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs1, rs2, rd;
    logic             use1, use2, mem_read, branch, mc_start, mc_done;
    logic             pc_write, if_id_write, bubble, flush, ex_hold, mc_timeout;
    logic [CNT_W-1:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: remaining load-stall cycles, elapsed multi-cycle cycles
    int m_ld_left  = 0;
    int m_mc_elap  = 0;
    bit m_mc_act   = 0;
    bit m_tmo      = 0;
    int m_cnt      = 0;

    hazard_stall_ctrl #(
        .LOAD_LAT  (LOAD_LAT),
        .MC_TIMEOUT(MC_TIMEOUT),
        .CNT_W     (CNT_W)
    ) u_dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_if_id_Rs1    (rs1),
        .i_if_id_Rs2    (rs2),
        .i_if_id_use_rs1(use1),
        .i_if_id_use_rs2(use2),
        .i_id_ex_Rd     (rd),
        .i_id_ex_MemRead(mem_read),
        .i_branch_taken (branch),
        .i_mc_start     (mc_start),
        .i_mc_done      (mc_done),
        .o_pc_write     (pc_write),
        .o_if_id_write  (if_id_write),
        .o_id_ex_bubble (bubble),
        .o_if_id_flush  (flush),
        .o_ex_hold      (ex_hold),
        .o_mc_timeout   (mc_timeout),
        .o_stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst = 0; rs1 = 0; rs2 = 0; rd = 0; use1 = 0; use2 = 0;
        mem_read = 0; branch = 0; mc_start = 0; mc_done = 0;
    endtask

    task automatic check_val(input string tag, input int act, input int exp);
        n_cmp++;
        assert (act === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock: compare outputs mid-cycle against the model, advance the model
    task automatic step(input string tag);
        bit pcw, ifw, bub, fl, hd, lu, tmo_now;
        logic [5:0] exp_ctl, act_ctl;
        @(negedge clk);
        if (rst) begin
            m_ld_left = 0; m_mc_elap = 0; m_mc_act = 0; m_tmo = 0; m_cnt = 0;
        end else begin
            pcw = 1; ifw = 1; bub = 0; fl = 0; hd = 0;
            tmo_now = m_tmo;
            lu = mem_read && (rd != 0) && ((use1 && rd == rs1) || (use2 && rd == rs2));
            if (m_mc_act) begin
                if (mc_done) begin
                    m_mc_act = 0;
                end else begin
                    pcw = 0; ifw = 0; hd = 1;
                    m_mc_elap++;
                    if (m_mc_elap == MC_TIMEOUT) begin
                        m_tmo = 1;
                        m_mc_act = 0;
                    end
                end
            end else if (m_ld_left > 0) begin
                if (branch) begin
                    fl = 1; bub = 1; m_ld_left = 0;
                end else begin
                    pcw = 0; ifw = 0; bub = 1; m_ld_left--;
                end
            end else if (branch) begin
                fl = 1; bub = 1;
            end else if (mc_start) begin
                if (!mc_done) begin
                    pcw = 0; ifw = 0; hd = 1; m_mc_act = 1; m_mc_elap = 1;
                end
            end else if (lu) begin
                pcw = 0; ifw = 0; bub = 1; m_ld_left = LOAD_LAT - 1;
            end
            exp_ctl = {pcw, ifw, bub, fl, hd, tmo_now};
            act_ctl = {pc_write, if_id_write, bubble, flush, ex_hold, mc_timeout};
            n_cmp++;
            assert (act_ctl === exp_ctl) else begin
                n_bad++;
                $error("FAIL %s ctl{pcw,ifw,bub,flush,hold,tmo}: observed %b expected %b",
                       tag, act_ctl, exp_ctl);
            end
            check_val({tag, " stall_cnt"}, int'(stall_cnt), m_cnt);
            if (!pcw && m_cnt < CNT_MAX) m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input logic [4:0] r, input logic [4:0] s1, input logic [4:0] s2,
                            input logic u1, input logic u2);
        mem_read = 1; rd = r; rs1 = s1; rs2 = s2; use1 = u1; use2 = u2;
    endtask

    initial begin
        idle();
        #1;
        // Reset and idle
        rst = 1; step("rst0"); step("rst1");
        idle(); step("idle");
        check_val("reset_cnt", int'(stall_cnt), 0);
        check_val("reset_pcw", int'(pc_write), 1);

        // Load-use on Rs2
        set_load(5, 1, 5, 1, 1); step("lu_rs2_a"); step("lu_rs2_b");
        idle(); step("lu_rs2_exit");
        check_val("lu_cnt", int'(stall_cnt), 2);

        // No hazard with Rd=0 or unused Rs2; both sources matching
        set_load(0, 0, 0, 1, 1); step("lu_rd0");
        set_load(5, 3, 5, 1, 0); step("lu_nouse");
        set_load(5, 5, 5, 1, 1); step("lu_both_a"); step("lu_both_b");
        idle(); step("lu_both_exit");
        check_val("lu_both_cnt", int'(stall_cnt), 4);

        // Multi-cycle op released on done; start+done together
        mc_start = 1; step("mc_start");
        mc_start = 0; repeat (4) step("mc_busy");
        mc_done = 1; step("mc_done");
        mc_done = 0; step("mc_after");
        mc_start = 1; mc_done = 1; step("mc_same");
        idle(); step("mc_same_after");
        check_val("mc_cnt", int'(stall_cnt), 9);

        // Timeout, sticky until reset
        mc_start = 1; step("tmo_start");
        mc_start = 0; repeat (70) step("tmo_wait");
        check_val("tmo_flag", int'(mc_timeout), 1);
        check_val("tmo_cnt", int'(stall_cnt), 73);
        repeat (3) step("tmo_sticky");
        rst = 1; step("tmo_rst");
        idle(); step("tmo_clear");
        check_val("tmo_cleared", int'(mc_timeout), 0);

        // Branch beats load-use; branch aborts a load stall
        set_load(5, 5, 0, 1, 0); branch = 1; step("br_lu");
        idle(); step("br_lu_after");
        check_val("br_lu_cnt", int'(stall_cnt), 0);
        set_load(7, 0, 7, 0, 1); step("br_ld_enter");
        idle(); branch = 1; step("br_ld_abort");
        idle(); step("br_ld_after");
        check_val("br_ld_cnt", int'(stall_cnt), 1);

        // Reset in the middle of a multi-cycle stall
        mc_start = 1; step("mid_start");
        mc_start = 0; step("mid_busy");
        rst = 1; step("mid_rst");
        idle(); step("mid_release");
        check_val("mid_cnt", int'(stall_cnt), 0);

        // Counter saturation
        repeat (5) begin
            mc_start = 1; step("sat_start");
            mc_start = 0; repeat (64) step("sat_busy");
        end
        idle(); step("sat_idle");
        check_val("sat_cnt", int'(stall_cnt), CNT_MAX);
        rst = 1; step("rnd_rst");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(99) == 0);
            mem_read = $urandom_range(1);
            rd       = 5'($urandom_range(3));
            rs1      = 5'($urandom_range(3));
            rs2      = 5'($urandom_range(3));
            use1     = $urandom_range(1);
            use2     = $urandom_range(1);
            branch   = ($urandom_range(9) == 0);
            mc_start = ($urandom_range(9) == 0);
            mc_done  = ($urandom_range(3) == 0);
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
